// File: rtl/eth_phy_10g_tx_if_pkg.sv
// Shared constants for the 10GBASE-R transmit interface: scrambler and
// PRBS31 polynomials/seeds plus the 64b/66b sync header codes.
package eth_phy_10g_tx_if_pkg;

   localparam int unsigned SCRAMBLER_WIDTH = 58;
   localparam logic [SCRAMBLER_WIDTH-1:0] SCRAMBLER_POLY = 58'h8000000001;
   localparam logic [SCRAMBLER_WIDTH-1:0] SCRAMBLER_SEED = '1;

   localparam int unsigned PRBS31_WIDTH = 31;
   localparam logic [PRBS31_WIDTH-1:0] PRBS31_POLY = 31'h10000001;
   localparam logic [PRBS31_WIDTH-1:0] PRBS31_SEED = 31'h7fffffff;

   typedef enum logic [1:0] {
      SYNC_DATA = 2'b01,
      SYNC_CTRL = 2'b10
   } sync_hdr_e;

endpackage

// File: rtl/eth_phy_10g_tx_if_lfsr.sv
// Combinational Fibonacci LFSR/scrambler stepping DATA_WIDTH bits per call.
// State bit 0 holds the most recent feedback bit.
module ve_lfsr #(
   parameter int unsigned LFSR_WIDTH = 58,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 58'h8000000001,
   parameter bit REVERSE = 1'b1,
   parameter bit FEED_FORWARD = 1'b0,
   parameter int unsigned DATA_WIDTH = 64,
   parameter STYLE = "AUTO"
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] state_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [LFSR_WIDTH-1:0] state_out
);

   localparam bit STYLE_OK = (STYLE == "AUTO") || (STYLE == "LOOP");

   if (!STYLE_OK) begin : g_bad_style
      $error("ve_lfsr: unsupported STYLE");
   end

   // POLY bit k stands for x^k with x^W implicit; x^k taps the bit k steps ago
   localparam logic [LFSR_WIDTH-1:0] TAPS = {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]};

   always_comb begin : p_step
      logic [LFSR_WIDTH-1:0] s;
      logic                  fb;
      logic                  din;
      int unsigned           idx;
      s        = state_in;
      data_out = '0;
      fb       = 1'b0;
      din      = 1'b0;
      idx      = 0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         idx           = REVERSE ? i : (DATA_WIDTH - 1 - i);
         din           = data_in[idx];
         fb            = ^(s & TAPS);
         data_out[idx] = din ^ fb;
         s             = {s[LFSR_WIDTH-2:0], (FEED_FORWARD ? din : (din ^ fb))};
      end
      state_out = s;
   end

endmodule

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R PHY transmit interface: 64b/66b scrambler or inverted PRBS31
// pattern, output register, optional bit reverse and SERDES pipeline.
module eth_phy_10g_tx_if
   import eth_phy_10g_tx_if_pkg::*;
#(
   parameter int DATA_WIDTH        = 64,
   parameter int HDR_WIDTH         = 2,
   parameter bit BIT_REVERSE       = 1'b0,
   parameter bit SCRAMBLER_DISABLE = 1'b0,
   parameter bit PRBS31_ENABLE     = 1'b0,
   parameter int SERDES_PIPELINE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] encoded_tx_data,
   input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
   output logic [DATA_WIDTH-1:0] serdes_tx_data,
   output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
   input  logic                  tx_prbs31_enable
);

   localparam int PRBS_WIDTH = DATA_WIDTH + HDR_WIDTH;

   if (DATA_WIDTH != 64) begin : g_bad_dw
      $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
   end
   if (HDR_WIDTH != 2) begin : g_bad_hw
      $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
   end

   logic [SCRAMBLER_WIDTH-1:0] scrambler_state_q, scrambler_state_d;
   logic [PRBS31_WIDTH-1:0]    prbs31_state_q, prbs31_state_d;
   logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
   logic [HDR_WIDTH-1:0]       out_hdr_q, out_hdr_d;

   logic [DATA_WIDTH-1:0]      scrambled_data;
   logic [SCRAMBLER_WIDTH-1:0] scrambler_state_next;
   logic [PRBS_WIDTH-1:0]      prbs_out;
   logic [PRBS31_WIDTH-1:0]    prbs_state_next;
   logic                       prbs_active;

   ve_lfsr #(
      .LFSR_WIDTH   (SCRAMBLER_WIDTH),
      .LFSR_POLY    (SCRAMBLER_POLY),
      .REVERSE      (1'b1),
      .FEED_FORWARD (1'b0),
      .DATA_WIDTH   (DATA_WIDTH),
      .STYLE        ("AUTO")
   ) u_scrambler (
      .data_in   (encoded_tx_data),
      .state_in  (scrambler_state_q),
      .data_out  (scrambled_data),
      .state_out (scrambler_state_next)
   );

   if (PRBS31_ENABLE) begin : g_prbs
      ve_lfsr #(
         .LFSR_WIDTH   (PRBS31_WIDTH),
         .LFSR_POLY    (PRBS31_POLY),
         .REVERSE      (1'b1),
         .FEED_FORWARD (1'b0),
         .DATA_WIDTH   (PRBS_WIDTH),
         .STYLE        ("AUTO")
      ) u_prbs31 (
         .data_in   ({PRBS_WIDTH{1'b0}}),
         .state_in  (prbs31_state_q),
         .data_out  (prbs_out),
         .state_out (prbs_state_next)
      );
      assign prbs_active = tx_prbs31_enable;
   end else begin : g_no_prbs
      logic unused_prbs_enable;
      assign unused_prbs_enable = tx_prbs31_enable;
      assign prbs_out           = '0;
      assign prbs_state_next    = PRBS31_SEED;
      assign prbs_active        = 1'b0;
   end

   // Scrambler advances every cycle, even while the PRBS pattern is sent
   always_comb begin
      scrambler_state_d = scrambler_state_next;
      prbs31_state_d    = prbs_active ? prbs_state_next : prbs31_state_q;
      out_hdr_d         = encoded_tx_hdr;
      out_data_d        = SCRAMBLER_DISABLE ? encoded_tx_data : scrambled_data;
      if (prbs_active) begin
         out_data_d = ~prbs_out[PRBS_WIDTH-1:HDR_WIDTH];
         out_hdr_d  = ~prbs_out[HDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scrambler_state_q <= SCRAMBLER_SEED;
         prbs31_state_q    <= PRBS31_SEED;
         out_data_q        <= '0;
         out_hdr_q         <= '0;
      end else begin
         scrambler_state_q <= scrambler_state_d;
         prbs31_state_q    <= prbs31_state_d;
         out_data_q        <= out_data_d;
         out_hdr_q         <= out_hdr_d;
      end
   end

   logic [DATA_WIDTH-1:0] rev_data;
   logic [HDR_WIDTH-1:0]  rev_hdr;

   if (BIT_REVERSE) begin : g_rev
      always_comb begin
         rev_data = '0;
         rev_hdr  = '0;
         for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            rev_data[i] = out_data_q[DATA_WIDTH-1-i];
         end
         for (int unsigned i = 0; i < HDR_WIDTH; i++) begin
            rev_hdr[i] = out_hdr_q[HDR_WIDTH-1-i];
         end
      end
   end else begin : g_no_rev
      assign rev_data = out_data_q;
      assign rev_hdr  = out_hdr_q;
   end

   if (SERDES_PIPELINE > 0) begin : g_pipe
      (* srl_style = "register" *)
      logic [DATA_WIDTH-1:0] pipe_data_q [SERDES_PIPELINE] = '{default: '0};
      (* srl_style = "register" *)
      logic [HDR_WIDTH-1:0]  pipe_hdr_q  [SERDES_PIPELINE] = '{default: '0};

      always_ff @(posedge clk) begin
         pipe_data_q[0] <= rev_data;
         pipe_hdr_q[0]  <= rev_hdr;
         for (int unsigned i = 1; i < SERDES_PIPELINE; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
            pipe_hdr_q[i]  <= pipe_hdr_q[i-1];
         end
      end

      assign serdes_tx_data = pipe_data_q[SERDES_PIPELINE-1];
      assign serdes_tx_hdr  = pipe_hdr_q[SERDES_PIPELINE-1];
   end else begin : g_no_pipe
      assign serdes_tx_data = rev_data;
      assign serdes_tx_hdr  = rev_hdr;
   end

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Scoreboard bench for eth_phy_10g_tx_if: a scrambling/PRBS instance with a
// 2-stage pipeline and a bit-reversed passthrough instance.
module tb_eth_phy_10g_tx_if;
   import eth_phy_10g_tx_if_pkg::*;

   localparam int PIPE_A = 2;
   localparam int PIPE_B = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_prbs31_enable = 1'b0;
   logic [63:0] encoded_tx_data = '0;
   logic [1:0]  encoded_tx_hdr = 2'b01;
   logic [63:0] a_data, b_data;
   logic [1:0]  a_hdr, b_hdr;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int          cyc;
      logic [63:0] d;
      logic [1:0]  h;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   logic [57:0] m_scr  = '1;
   logic [30:0] m_prbs = '1;

   eth_phy_10g_tx_if #(
      .DATA_WIDTH        (64),
      .HDR_WIDTH         (2),
      .BIT_REVERSE       (1'b0),
      .SCRAMBLER_DISABLE (1'b0),
      .PRBS31_ENABLE     (1'b1),
      .SERDES_PIPELINE   (PIPE_A)
   ) dut_a (
      .clk              (clk),
      .rst              (rst),
      .encoded_tx_data  (encoded_tx_data),
      .encoded_tx_hdr   (encoded_tx_hdr),
      .serdes_tx_data   (a_data),
      .serdes_tx_hdr    (a_hdr),
      .tx_prbs31_enable (tx_prbs31_enable)
   );

   eth_phy_10g_tx_if #(
      .DATA_WIDTH        (64),
      .HDR_WIDTH         (2),
      .BIT_REVERSE       (1'b1),
      .SCRAMBLER_DISABLE (1'b1),
      .PRBS31_ENABLE     (1'b0),
      .SERDES_PIPELINE   (PIPE_B)
   ) dut_b (
      .clk              (clk),
      .rst              (rst),
      .encoded_tx_data  (encoded_tx_data),
      .encoded_tx_hdr   (encoded_tx_hdr),
      .serdes_tx_data   (b_data),
      .serdes_tx_hdr    (b_hdr),
      .tx_prbs31_enable (tx_prbs31_enable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = v[63-i];
      return r;
   endfunction

   function automatic logic [63:0] pattern(input int i);
      logic [63:0] v;
      v = 64'h9e3779b97f4a7c15 * (i + 1);
      return v ^ {v[31:0], v[63:32]};
   endfunction

   // Bit-serial x^58+x^39+1 scrambler and x^31+x^28+1 PRBS reference
   task automatic apply(input logic r, input logic pe, input logic [63:0] d,
                        input logic [1:0] h, input bit use_hand = 1'b0,
                        input logic [63:0] hand_d = '0);
      logic [63:0] sd;
      logic [65:0] g;
      logic        o;
      exp_t        ea, eb;
      @(posedge clk);
      #1;
      rst              = r;
      tx_prbs31_enable = pe;
      encoded_tx_data  = d;
      encoded_tx_hdr   = h;
      ea.cyc = cyc;
      eb.cyc = cyc;
      if (r) begin
         m_scr  = '1;
         m_prbs = '1;
         ea.d = '0; ea.h = '0;
         eb.d = '0; eb.h = '0;
      end else begin
         for (int i = 0; i < 64; i++) begin
            o     = d[i] ^ m_scr[38] ^ m_scr[57];
            sd[i] = o;
            m_scr = {m_scr[56:0], o};
         end
         if (pe) begin
            for (int i = 0; i < 66; i++) begin
               o      = m_prbs[27] ^ m_prbs[30];
               g[i]   = o;
               m_prbs = {m_prbs[29:0], o};
            end
            ea.d = ~g[65:2];
            ea.h = ~g[1:0];
         end else begin
            ea.d = use_hand ? hand_d : sd;
            ea.h = h;
         end
         eb.d = rev64(d);
         eb.h = {h[0], h[1]};
      end
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   always @(negedge clk) begin
      if (qa.size() > 0 && qa[0].cyc + 1 + PIPE_A <= cyc) begin
         vectors++;
         if (qa[0].cyc + 1 + PIPE_A != cyc || a_data !== qa[0].d || a_hdr !== qa[0].h) begin
            miscompares++;
            $display("FAIL scr_path cyc=%0d data got %h want %h hdr got %b want %b",
                     qa[0].cyc, a_data, qa[0].d, a_hdr, qa[0].h);
         end
         void'(qa.pop_front());
      end
      if (qb.size() > 0 && qb[0].cyc + 1 + PIPE_B <= cyc) begin
         vectors++;
         if (qb[0].cyc + 1 + PIPE_B != cyc || b_data !== qb[0].d || b_hdr !== qb[0].h) begin
            miscompares++;
            $display("FAIL rev_path cyc=%0d data got %h want %h hdr got %b want %b",
                     qb[0].cyc, b_data, qb[0].d, b_hdr, qb[0].h);
         end
         void'(qb.pop_front());
      end
   end

   initial begin
      apply(1'b1, 1'b0, 64'hdeadbeefcafef00d, SYNC_DATA);
      apply(1'b1, 1'b0, '0, SYNC_DATA);
      // all-zero block from seed: ones appear only at bits 39..57
      apply(1'b0, 1'b0, '0, SYNC_DATA, 1'b1, 64'h03ffff8000000000);
      apply(1'b0, 1'b0, 64'h0123456789abcdef, SYNC_DATA);
      apply(1'b0, 1'b0, 64'h0000000000000001, SYNC_DATA);
      apply(1'b0, 1'b0, '1, SYNC_CTRL);
      apply(1'b0, 1'b0, 64'haaaaaaaaaaaaaaaa, SYNC_DATA);
      apply(1'b0, 1'b0, 64'h5555555555555555, SYNC_CTRL);
      for (int i = 0; i < 24; i++)
         apply(1'b0, 1'b0, pattern(i), (i % 2) ? SYNC_CTRL : SYNC_DATA);
      for (int i = 0; i < 5; i++)
         apply(1'b0, 1'b1, pattern(i + 40), SYNC_DATA);
      for (int i = 0; i < 8; i++)
         apply(1'b0, 1'b0, pattern(i + 50), SYNC_DATA);
      apply(1'b1, 1'b0, pattern(60), SYNC_DATA);
      apply(1'b0, 1'b0, '0, SYNC_DATA, 1'b1, 64'h03ffff8000000000);
      for (int i = 0; i < 6; i++)
         apply(1'b0, 1'b0, pattern(i + 70), SYNC_CTRL);
      for (int i = 0; i < 8; i++)
         apply(1'b0, 1'b1, pattern(i + 80), SYNC_DATA);
      for (int i = 0; i < 4; i++)
         apply(1'b0, 1'b0, pattern(i + 90), SYNC_DATA);
      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++)
         @(posedge clk);
      @(negedge clk);
      #1;
      if (qa.size() > 0 || qb.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending got %0d want 0", qa.size() + qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
